// File: rtl/stream_distributor_if.sv
// Stream bundle for the 1-to-N distributor: one upstream AXI-Stream in,
// KERNEL_SIZE downstream channels out (channel i at bit i / slice i).
interface stream_distributor_if #(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 18
);
  // A beat transfers on a channel at a rising edge where valid and ready are
  // both 1; valid and data hold steady while valid=1 and ready=0.
  logic                              s_axis_tvalid;
  logic [DATA_WIDTH-1:0]             s_axis_tdata;
  logic                              s_axis_tlast;
  logic                              s_axis_tready;
  logic [KERNEL_SIZE-1:0]            m_axis_tvalid;
  logic [DATA_WIDTH*KERNEL_SIZE-1:0] m_axis_tdata;
  logic [KERNEL_SIZE-1:0]            m_axis_tready;

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata
  );

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata
  );
endinterface

// File: rtl/stream_distributor.sv
// Deals input beats round-robin to KERNEL_SIZE channels, each behind its own
// small FIFO; tlast restarts the deal at channel 0.
module stream_distributor #(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 18,
  parameter int FIFO_DEPTH  = 2,
  localparam int PTR_W      = $clog2(KERNEL_SIZE)
) (
  input  logic             clk,
  input  logic             rstn,
  stream_distributor_if.slave bus,
  output logic [PTR_W-1:0] ptr
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int OCC_W = AW + 1;

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [AW-1:0]         wr_ptr_q [KERNEL_SIZE];
  logic [AW-1:0]         wr_ptr_d [KERNEL_SIZE];
  logic [AW-1:0]         rd_ptr_q [KERNEL_SIZE];
  logic [AW-1:0]         rd_ptr_d [KERNEL_SIZE];
  logic [OCC_W-1:0]      occ_q    [KERNEL_SIZE];
  logic [OCC_W-1:0]      occ_d    [KERNEL_SIZE];
  logic [DATA_WIDTH-1:0] mem_q    [KERNEL_SIZE][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d    [KERNEL_SIZE][FIFO_DEPTH];

  logic [KERNEL_SIZE-1:0] full, empty, push, pop;
  logic                   accept;

  always_comb begin
    full  = '0;
    empty = '0;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      full[i]  = (occ_q[i] == OCC_W'(FIFO_DEPTH));
      empty[i] = (occ_q[i] == '0);
    end
  end

  // Ready looks only at the current destination FIFO: no skipping ahead.
  assign bus.s_axis_tready = rstn & ~full[ptr_q];
  assign accept            = bus.s_axis_tvalid & bus.s_axis_tready;
  assign ptr               = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      if (bus.s_axis_tlast || (ptr_q == PTR_W'(KERNEL_SIZE - 1)))
        ptr_d = '0;
      else
        ptr_d = ptr_q + 1'b1;
    end
  end

  always_comb begin
    mem_d             = mem_q;
    push              = '0;
    pop               = '0;
    bus.m_axis_tvalid = '0;
    bus.m_axis_tdata  = '0;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      occ_d[i]    = occ_q[i];
      push[i]     = accept && (ptr_q == PTR_W'(i));
      pop[i]      = ~empty[i] & bus.m_axis_tready[i];

      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = bus.s_axis_tdata;
        wr_ptr_d[i]           = wr_ptr_q[i] + 1'b1;
      end
      if (pop[i])
        rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;

      case ({push[i], pop[i]})
        2'b10:   occ_d[i] = occ_q[i] + 1'b1;
        2'b01:   occ_d[i] = occ_q[i] - 1'b1;
        default: occ_d[i] = occ_q[i];
      endcase

      // Output is always the registered head: a fresh beat shows one cycle later.
      bus.m_axis_tvalid[i]                          = ~empty[i];
      bus.m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i][rd_ptr_q[i]];
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rstn) begin
      ptr_q <= '0;
      for (int i = 0; i < KERNEL_SIZE; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        occ_q[i]    <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int i = 0; i < KERNEL_SIZE; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        occ_q[i]    <= occ_d[i];
      end
    end
  end
endmodule

// File: tb/tb_stream_distributor.sv
// Bench for stream_distributor: per-channel expected queues fed at accept
// time, drained by an independent output monitor.
module tb_stream_distributor;
  localparam int KS    = 3;
  localparam int DW    = 18;
  localparam int DEPTH = 2;

  // clock / reset
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data  = '0;
  logic          s_last  = 1'b0;
  logic [KS-1:0] m_ready = '0;
  logic [1:0]    ptr;

  stream_distributor_if #(.KERNEL_SIZE(KS), .DATA_WIDTH(DW)) bus ();

  assign bus.s_axis_tvalid = s_valid;
  assign bus.s_axis_tdata  = s_data;
  assign bus.s_axis_tlast  = s_last;
  assign bus.m_axis_tready = m_ready;

  stream_distributor #(.KERNEL_SIZE(KS), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus),
    .ptr  (ptr)
  );

  // scoreboard
  logic [DW-1:0] exp_q [KS][$];
  int            total = 0;
  int            bad   = 0;
  int            frame_idx = 0;   // beats accepted so far in the current frame
  bit            mon_en = 1'b0;
  bit            last_acc = 1'b0;
  logic [KS-1:0] pop_pend = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // driver: one clock of stimulus; inputs change only just after the rising edge
  task automatic step();
    int   ch;
    logic exp_ready;
    bit   acc;
    @(negedge clk);
    ch        = frame_idx % KS;
    exp_ready = rstn && (exp_q[ch].size() < DEPTH);
    chk("s_ready", 32'(bus.s_axis_tready), 32'(exp_ready));
    if (rstn && mon_en) chk("ptr", 32'(ptr), 32'(ch));
    acc = exp_ready && s_valid;
    @(posedge clk);
    if (!rstn) begin
      for (int i = 0; i < KS; i++) exp_q[i].delete();
      frame_idx = 0;
    end else if (acc) begin
      exp_q[ch].push_back(s_data);
      frame_idx = s_last ? 0 : frame_idx + 1;
    end
    last_acc = acc;
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_acc && n < 64);
    if (!last_acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = '1;
    for (int n = 0; n < 64; n++) begin
      done = 1'b1;
      for (int i = 0; i < KS; i++) if (exp_q[i].size() != 0) done = 1'b0;
      if (done) break;
      step();
    end
    for (int i = 0; i < KS; i++)
      if (exp_q[i].size() != 0) chk("drain_timeout", 32'(exp_q[i].size()), 32'd0);
  endtask

  // monitor: compares every channel each cycle; pops land at the next edge
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < KS; i++) begin
        bit ev;
        ev = (exp_q[i].size() != 0);
        chk($sformatf("valid[%0d]", i), 32'(bus.m_axis_tvalid[i]), 32'(ev));
        if (ev)
          chk($sformatf("data[%0d]", i), 32'(bus.m_axis_tdata[i*DW +: DW]), 32'(exp_q[i][0]));
        pop_pend[i] = ev && m_ready[i];
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < KS; i++)
      if (pop_pend[i] && exp_q[i].size() > 0) void'(exp_q[i].pop_front());
  end

  initial begin
    do_reset();
    mon_en = 1'b1;

    // back-to-back dealing
    m_ready = '1;
    send_beat(18'd100, 1'b0);
    send_beat(18'd200, 1'b0);
    send_beat(18'd300, 1'b0);
    send_beat(18'd400, 1'b0);
    s_valid = 1'b0;
    drain();

    // one stalled consumer
    do_reset();
    m_ready = 3'b101;
    for (int k = 1; k <= 7; k++) send_beat(DW'(10 * k), 1'b0);
    chk("t2_ptr", 32'(ptr), 32'd1);
    s_valid = 1'b1;
    s_data  = 18'd80;
    repeat (3) step();
    chk("t2_stalled", 32'(bus.s_axis_tready), 32'd0);
    m_ready = 3'b111;
    send_beat(18'd80, 1'b0);
    drain();

    // early tlast
    do_reset();
    m_ready = '1;
    send_beat(18'd55, 1'b0);
    send_beat(18'd66, 1'b1);
    send_beat(18'd77, 1'b0);
    s_valid = 1'b0;
    chk("t3_ptr", 32'(ptr), 32'd1);
    drain();

    // all FIFOs full
    do_reset();
    m_ready = '0;
    for (int k = 1; k <= 6; k++) send_beat(DW'(k), 1'b0);
    s_valid = 1'b0;
    chk("t4_valid", 32'(bus.m_axis_tvalid), 32'h7);
    chk("t4_ready", 32'(bus.s_axis_tready), 32'd0);
    chk("t4_ptr", 32'(ptr), 32'd0);
    m_ready = '1;
    step();
    m_ready = '0;
    chk("t4_resume", 32'(bus.s_axis_tready), 32'd1);
    step();
    drain();

    // reset with beats buffered
    m_ready = '0;
    send_beat(18'd11, 1'b0);
    send_beat(18'd22, 1'b0);
    send_beat(18'd33, 1'b0);
    send_beat(18'd44, 1'b0);
    s_valid = 1'b0;
    do_reset();
    chk("t5_valid", 32'(bus.m_axis_tvalid), 32'd0);
    chk("t5_ptr", 32'(ptr), 32'd0);
    m_ready = '1;
    send_beat(18'd1000, 1'b0);
    s_valid = 1'b0;
    step();
    step();
    drain();

    // gapped valid
    do_reset();
    m_ready = '1;
    s_valid = 1'b1; s_data = 18'd1111; s_last = 1'b0;
    step();
    s_valid = 1'b0;
    step();
    s_valid = 1'b1; s_data = 18'd2222;
    step();
    s_valid = 1'b0;
    step();
    chk("t6_ptr", 32'(ptr), 32'd2);
    drain();

    // randomized traffic with random back-pressure
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (!(s_valid && !last_acc)) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_data  = DW'($urandom);
        s_last  = ($urandom_range(0, 6) == 0);
      end
      m_ready = KS'($urandom_range(0, 7));
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
